// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader and instruction-memory port arbiter.
// Takes 32-bit host words over valid/ready and writes each one as two 16-bit
// halfwords into the instruction memory's write port. While no write is in
// progress, the memory address follows the core's fetch PC. The core stays
// stalled until a complete image has been written.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to add a trailing
// checksum beat, which is compared against the running halfword sum.
module imem_loader #(
  parameter int ADDRESS_WIDTH           = 6,
  parameter int DATA_WIDTH              = 32,
  parameter int SHORT_INSTRUCTION_WIDTH = DATA_WIDTH / 2,
  parameter int PROGRAM_ADDRESS_WIDTH   = ADDRESS_WIDTH + 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load_start,
  input  logic [ADDRESS_WIDTH-1:0]           load_len,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_WIDTH-1:0]              in_data,
  input  logic [PROGRAM_ADDRESS_WIDTH-1:0]   fetch_pc,
  output logic                               mem_write_en,
  output logic [SHORT_INSTRUCTION_WIDTH-1:0] mem_write_data,
  output logic [PROGRAM_ADDRESS_WIDTH-1:0]   mem_address,
  output logic                               core_stall,
  output logic                               load_done,
  output logic                               load_error
);

  localparam int SIW = SHORT_INSTRUCTION_WIDTH;
  localparam int PAW = PROGRAM_ADDRESS_WIDTH;

  // Largest image that fits: half the halfword depth, in 32-bit words.
  localparam logic [ADDRESS_WIDTH-1:0] MAX_LEN = ADDRESS_WIDTH'(1 << (ADDRESS_WIDTH - 1));

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, ACCEPT, WR_LO, WR_HI, CHECK, RUN} state_t;
`else
  typedef enum logic [2:0] {IDLE, ACCEPT, WR_LO, WR_HI, RUN} state_t;
`endif

  state_t                   state;
  logic [PAW-1:0]           ptr;      // byte address of the current word's low half
  logic [ADDRESS_WIDTH-1:0] cnt;      // words still to be written
  logic [SIW-1:0]           hi_half;  // upper halfword, held for the WR_HI beat
  logic [PAW-1:0]           wr_addr;  // address presented during a write beat
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [SIW-1:0]           sum;      // running mod-2^16 sum of written halfwords
`endif

  // Loader owns the address only while it is writing; otherwise fetch passes through.
  assign mem_address = mem_write_en ? wr_addr : fetch_pc;

  // Load sequencer: all outputs except mem_address are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= '0;
      cnt            <= '0;
      hi_half        <= '0;
      wr_addr        <= '0;
      in_ready       <= 1'b0;
      mem_write_en   <= 1'b0;
      mem_write_data <= '0;
      core_stall     <= 1'b1;
      load_done      <= 1'b0;
      load_error     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum            <= '0;
`endif
    end else begin
      case (state)
        IDLE, RUN: begin
          if (load_start) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum <= '0;
`endif
            if (load_len == '0) begin
              state      <= RUN;
              core_stall <= 1'b0;
              load_done  <= 1'b1;
              load_error <= 1'b0;
            end else if (load_len > MAX_LEN) begin
              state      <= IDLE;
              core_stall <= 1'b1;
              load_done  <= 1'b0;
              load_error <= 1'b1;
            end else begin
              state      <= ACCEPT;
              ptr        <= '0;
              cnt        <= load_len;
              core_stall <= 1'b1;
              load_done  <= 1'b0;
              load_error <= 1'b0;
              in_ready   <= 1'b1;
            end
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            // The low half goes straight to the write port; the high half waits one beat.
            hi_half        <= in_data[DATA_WIDTH-1:SIW];
            mem_write_data <= in_data[SIW-1:0];
            wr_addr        <= ptr;
            mem_write_en   <= 1'b1;
            in_ready       <= 1'b0;
            state          <= WR_LO;
          end
        end
        WR_LO: begin
          mem_write_data <= hi_half;
          wr_addr        <= ptr + PAW'(2);
          state          <= WR_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum            <= sum + mem_write_data;
`endif
        end
        WR_HI: begin
          mem_write_en <= 1'b0;
          ptr          <= ptr + PAW'(4);
          cnt          <= cnt - ADDRESS_WIDTH'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum          <= sum + mem_write_data;
`endif
          if (cnt == ADDRESS_WIDTH'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state      <= CHECK;
            in_ready   <= 1'b1;
`else
            state      <= RUN;
            core_stall <= 1'b0;
            load_done  <= 1'b1;
`endif
          end else begin
            state    <= ACCEPT;
            in_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (in_data[SIW-1:0] == sum) begin
              state      <= RUN;
              core_stall <= 1'b0;
              load_done  <= 1'b1;
            end else begin
              state      <= IDLE;
              core_stall <= 1'b1;
              load_error <= 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader. It includes a behavioural halfword memory
// and a write log, so that memory contents and write ordering can be checked
// against hand-computed values.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [5:0]  load_len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [6:0]  fetch_pc;
  logic        mem_write_en;
  logic [15:0] mem_write_data;
  logic [6:0]  mem_address;
  logic        core_stall;
  logic        load_done;
  logic        load_error;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [0:63];
  logic        mem_clr = 1'b0;
  int          wr_cnt = 0;
  logic [6:0]  log_addr [0:511];
  logic [15:0] log_data [0:511];
  int          ready_wr_viol = 0;
  logic [15:0] run_sum;

  imem_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .fetch_pc(fetch_pc), .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
    .mem_address(mem_address), .core_stall(core_stall), .load_done(load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  // Instruction memory model, write log and handshake monitor.
  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 64; i++) mem[i] <= 16'h0;
    else if (mem_write_en) mem[mem_address[6:1]] <= mem_write_data;
    if (mem_write_en) begin
      log_addr[wr_cnt % 512] <= mem_address;
      log_data[wr_cnt % 512] <= mem_write_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_write_en && in_ready) ready_wr_viol <= ready_wr_viol + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [31:0] rd_word();
    logic [5:0] a;
    a = mem_address[6:1];
    return {mem[a + 6'd1], mem[a]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mem();
    mem_clr = 1'b1; tick(1); mem_clr = 1'b0;
  endtask

  task automatic start_load(input logic [5:0] len);
    load_start = 1'b1; load_len = len; run_sum = 16'h0;
    tick(1);
    load_start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin tick(1); n++; end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL send_ready_timeout got=%b want=1", in_ready);
    end else begin
      tick(gap);
      in_valid = 1'b1; in_data = w;
      tick(1);
      in_valid = 1'b0; in_data = 32'h0;
    end
  endtask

  task automatic send_data(input logic [31:0] w, input int gap);
    run_sum = run_sum + w[15:0] + w[31:16];
    send_word(w, gap);
  endtask

  task automatic send_check();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word({16'h0, run_sum}, 0);
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; load_start = 1'b0; load_len = 6'd0; in_valid = 1'b0;
    in_data = 32'h0; fetch_pc = 7'h10; run_sum = 16'h0;
    tick(2);
    total++; if (core_stall !== 1'b1) begin bad++; $display("FAIL reset_stall got=%b want=1", core_stall); end
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", load_done); end
    total++; if (load_error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", load_error); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", in_ready); end
    total++; if (mem_write_en !== 1'b0) begin bad++; $display("FAIL reset_wen got=%b want=0", mem_write_en); end
    total++; if (mem_address !== 7'h10) begin bad++; $display("FAIL reset_addr_mux got=%h want=10", mem_address); end
    clear_mem();
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_basic();
    int base;
    logic [6:0]  ea [4];
    logic [15:0] ed [4];
    ea = '{7'd0, 7'd2, 7'd4, 7'd6};
    ed = '{16'h0093, 16'h00B3, 16'h0013, 16'h0073};
    base = wr_cnt;
    start_load(6'd2);
    total++; if (in_ready !== 1'b1 || core_stall !== 1'b1) begin bad++; $display("FAIL basic_accept ready=%b stall=%b want 1 1", in_ready, core_stall); end
    send_data(32'h00B30093, 0);
    send_data(32'h00730013, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_check();
    total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL basic_stall_after_check got=%b want=0", core_stall); end
`else
    total++; if (core_stall !== 1'b1) begin bad++; $display("FAIL basic_stall_lat1 got=%b want=1", core_stall); end
    tick(1);
    total++; if (core_stall !== 1'b1) begin bad++; $display("FAIL basic_stall_lat2 got=%b want=1", core_stall); end
    tick(1);
    total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL basic_stall_lat3 got=%b want=0", core_stall); end
`endif
    total++; if (load_done !== 1'b1 || load_error !== 1'b0) begin bad++; $display("FAIL basic_flags done=%b err=%b want 1 0", load_done, load_error); end
    total++; if (wr_cnt - base != 4) begin bad++; $display("FAIL basic_write_count got=%0d want=4", wr_cnt - base); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (log_addr[(base + i) % 512] !== ea[i] || log_data[(base + i) % 512] !== ed[i]) begin
        bad++; $display("FAIL basic_write%0d got=%h@%0d want=%h@%0d", i, log_data[(base + i) % 512], log_addr[(base + i) % 512], ed[i], ea[i]);
      end
    end
    fetch_pc = 7'd0; #1;
    total++; if (rd_word() !== 32'h00B30093) begin bad++; $display("FAIL basic_read0 got=%h want=00b30093", rd_word()); end
    fetch_pc = 7'd4; #1;
    total++; if (mem_address !== 7'd4 || rd_word() !== 32'h00730013) begin bad++; $display("FAIL basic_read4 addr=%0d got=%h want=4 00730013", mem_address, rd_word()); end
    tick(1);
  endtask

  task automatic test_gaps();
    int base, viol0;
    clear_mem();
    base = wr_cnt; viol0 = ready_wr_viol;
    start_load(6'd2);
    send_data(32'h00B30093, 3);
    tick(2);
    // a load_start while loading must be ignored
    load_start = 1'b1; load_len = 6'd0;
    tick(1);
    load_start = 1'b0;
    total++; if (in_ready !== 1'b1 || core_stall !== 1'b1 || load_done !== 1'b0) begin bad++; $display("FAIL gaps_ignore_start ready=%b stall=%b done=%b want 1 1 0", in_ready, core_stall, load_done); end
    send_data(32'h00730013, 2);
    send_check();
    tick(3);
    total++; if (load_done !== 1'b1 || core_stall !== 1'b0) begin bad++; $display("FAIL gaps_done done=%b stall=%b want 1 0", load_done, core_stall); end
    total++; if (wr_cnt - base != 4) begin bad++; $display("FAIL gaps_write_count got=%0d want=4", wr_cnt - base); end
    total++; if ({mem[1], mem[0], mem[3], mem[2]} !== 64'h00B30093_00730013) begin bad++; $display("FAIL gaps_mem got=%h%h%h%h want=00b3009300730013", mem[1], mem[0], mem[3], mem[2]); end
    total++; if (ready_wr_viol != viol0) begin bad++; $display("FAIL gaps_ready_in_wr got=%0d want=0", ready_wr_viol - viol0); end
    base = wr_cnt; tick(5);
    total++; if (wr_cnt != base) begin bad++; $display("FAIL gaps_idle_writes got=%0d want=0", wr_cnt - base); end
  endtask

  task automatic test_len_over();
    int base;
    base = wr_cnt;
    start_load(6'd33);
    total++; if (load_error !== 1'b1 || load_done !== 1'b0 || core_stall !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL len33 err=%b done=%b stall=%b ready=%b want 1 0 1 0", load_error, load_done, core_stall, in_ready); end
    tick(3);
    total++; if (wr_cnt != base || core_stall !== 1'b1) begin bad++; $display("FAIL len33_hold writes=%0d stall=%b want 0 1", wr_cnt - base, core_stall); end
  endtask

  task automatic test_len_zero();
    int base;
    base = wr_cnt;
    start_load(6'd0);
    total++; if (core_stall !== 1'b0 || load_done !== 1'b1 || load_error !== 1'b0) begin bad++; $display("FAIL len0 stall=%b done=%b err=%b want 0 1 0", core_stall, load_done, load_error); end
    tick(3);
    total++; if (wr_cnt != base) begin bad++; $display("FAIL len0_writes got=%0d want=0", wr_cnt - base); end
  endtask

  task automatic test_len_max();
    int base, errs;
    clear_mem();
    base = wr_cnt;
    start_load(6'd32);
    for (int i = 0; i < 32; i++)
      send_data({16'hA001 + 16'(2 * i), 16'hA000 + 16'(2 * i)}, 0);
    send_check();
    tick(3);
    total++; if (load_done !== 1'b1 || core_stall !== 1'b0) begin bad++; $display("FAIL len32_done done=%b stall=%b want 1 0", load_done, core_stall); end
    total++; if (wr_cnt - base != 64) begin bad++; $display("FAIL len32_write_count got=%0d want=64", wr_cnt - base); end
    errs = 0;
    for (int k = 0; k < 64; k++)
      if (mem[k] !== 16'hA000 + 16'(k)) begin
        errs++;
        if (errs == 1) $display("FAIL len32_mem[%0d] got=%h want=%h", k, mem[k], 16'hA000 + 16'(k));
      end
    total++; if (errs != 0) bad++;
  endtask

  task automatic test_reset_mid();
    int base;
    base = wr_cnt;
    start_load(6'd2);
    send_data(32'h11112222, 0);
    tick(1);
    total++; if (mem_write_en !== 1'b1 || mem_address !== 7'd2 || mem_write_data !== 16'h1111) begin bad++; $display("FAIL rstmid_wr_hi wen=%b addr=%0d data=%h want 1 2 1111", mem_write_en, mem_address, mem_write_data); end
    rst = 1'b1; #1;
    total++; if (mem_write_en !== 1'b0 || core_stall !== 1'b1 || load_done !== 1'b0 || load_error !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_abort wen=%b stall=%b done=%b err=%b ready=%b want 0 1 0 0 0", mem_write_en, core_stall, load_done, load_error, in_ready); end
    tick(1);
    rst = 1'b0;
    tick(1);
    total++; if (wr_cnt - base != 1 || mem[0] !== 16'h2222 || mem[1] !== 16'hA001) begin bad++; $display("FAIL rstmid_partial writes=%0d m0=%h m1=%h want 1 2222 a001", wr_cnt - base, mem[0], mem[1]); end
    start_load(6'd1);
    send_data(32'hCAFEBEEF, 0);
    send_check();
    tick(3);
    total++; if (load_done !== 1'b1 || core_stall !== 1'b0 || mem[0] !== 16'hBEEF || mem[1] !== 16'hCAFE) begin bad++; $display("FAIL rstmid_fresh done=%b stall=%b m0=%h m1=%h want 1 0 beef cafe", load_done, core_stall, mem[0], mem[1]); end
  endtask

  task automatic test_reload();
    int base;
    base = wr_cnt;
    start_load(6'd1);
    total++; if (core_stall !== 1'b1 || load_done !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL reload_start stall=%b done=%b ready=%b want 1 0 1", core_stall, load_done, in_ready); end
    send_data(32'h55556666, 0);
    send_check();
    tick(3);
    total++; if (load_done !== 1'b1 || core_stall !== 1'b0) begin bad++; $display("FAIL reload_done done=%b stall=%b want 1 0", load_done, core_stall); end
    total++; if (wr_cnt - base != 2 || log_addr[base % 512] !== 7'd0 || log_addr[(base + 1) % 512] !== 7'd2) begin bad++; $display("FAIL reload_writes n=%0d a0=%0d a1=%0d want 2 0 2", wr_cnt - base, log_addr[base % 512], log_addr[(base + 1) % 512]); end
    total++; if (mem[0] !== 16'h6666 || mem[1] !== 16'h5555 || mem[2] !== 16'hA002 || mem[63] !== 16'hA03F) begin bad++; $display("FAIL reload_mem m0=%h m1=%h m2=%h m63=%h want 6666 5555 a002 a03f", mem[0], mem[1], mem[2], mem[63]); end
  endtask

  task automatic test_checksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
    start_load(6'd1);
    send_data(32'h00010002, 0);
    send_word(32'h00000003, 0);
    total++; if (load_done !== 1'b1 || core_stall !== 1'b0 || load_error !== 1'b0) begin bad++; $display("FAIL csum_good done=%b stall=%b err=%b want 1 0 0", load_done, core_stall, load_error); end
    start_load(6'd1);
    send_data(32'h00010002, 0);
    send_word(32'h00000004, 0);
    total++; if (load_error !== 1'b1 || core_stall !== 1'b1 || load_done !== 1'b0) begin bad++; $display("FAIL csum_bad err=%b stall=%b done=%b want 1 1 0", load_error, core_stall, load_done); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_len_over();
    test_len_zero();
    test_len_max();
    test_reset_mid();
    test_reload();
    test_checksum();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
